// File: rtl/writeback_arbiter_if.sv
// Result/issue/write-port bundle between the execution pipes and the writeback arbiter.
// The arbiter takes the slave side; the pipes or a bench take the master side.
interface writeback_arbiter_if #(
  parameter int CNT_W = 3
);
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [31:0]      alu_data;
  logic             alu_ready;
  logic             lsu_valid;
  logic [4:0]       lsu_rd;
  logic [31:0]      lsu_data;
  logic             lsu_ready;
  logic             issue_valid;
  logic             issue_long;
  logic [4:0]       issue_rd;
  logic [4:0]       REG_write_address;
  logic             REG_write_enable;
  logic [31:0]      REG_write_value;
  logic [31:0]      busy_mask;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_long, issue_rd,
    input  alu_ready, lsu_ready, REG_write_address, REG_write_enable,
           REG_write_value, busy_mask, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_long, issue_rd,
    output alu_ready, lsu_ready, REG_write_address, REG_write_enable,
           REG_write_value, busy_mask, fifo_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: ALU results pass straight through, LSU results queue in a
// small FIFO, and a pending-destination mask tracks outstanding long-latency writes.
module writeback_arbiter #(
  parameter int LSU_FIFO_DEPTH = 4,
  parameter int CNT_W          = 3
) (
  input logic                 SYS_clk,
  input logic                 SYS_reset,
  writeback_arbiter_if.slave  bus
);
  localparam int PTR_W = CNT_W - 1;

  logic [4:0]       r_mem_rd   [LSU_FIFO_DEPTH];
  logic [31:0]      r_mem_data [LSU_FIFO_DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_busy;
  logic [4:0]       r_wr_addr;
  logic             r_wr_en;
  logic [31:0]      r_wr_val;

  logic             w_full, w_empty, w_push, w_pop, w_alu_win, w_set;
  logic [4:0]       w_head_rd, w_win_rd;
  logic [31:0]      w_head_data, w_win_data, w_busy_nxt;

  assign w_full      = (r_count == CNT_W'(LSU_FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_head_rd   = r_mem_rd[r_head];
  assign w_head_data = r_mem_data[r_head];

  // A full FIFO preempts the ALU; otherwise the ALU always wins and the FIFO takes idle slots.
  assign w_alu_win = !w_full && bus.alu_valid;
  assign w_pop     = w_full || (!bus.alu_valid && !w_empty);
  assign w_push    = bus.lsu_valid && !w_full;
  assign w_set     = bus.issue_valid && bus.issue_long && (bus.issue_rd != 5'd0);

  assign w_win_rd   = w_alu_win ? bus.alu_rd   : w_head_rd;
  assign w_win_data = w_alu_win ? bus.alu_data : w_head_data;

  assign bus.alu_ready         = !w_full;
  assign bus.lsu_ready         = !w_full;
  assign bus.REG_write_address = r_wr_addr;
  assign bus.REG_write_enable  = r_wr_en;
  assign bus.REG_write_value   = r_wr_val;
  assign bus.busy_mask         = r_busy;
  assign bus.fifo_count        = r_count;

  // Set is applied after clear so a same-cycle reissue of the popped rd stays pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head_rd] = 1'b0;
    if (w_set) w_busy_nxt[bus.issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge SYS_clk) begin
    if (w_push) begin
      r_mem_rd[r_tail]   <= bus.lsu_rd;
      r_mem_data[r_tail] <= bus.lsu_data;
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_busy    <= '0;
      r_wr_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_val  <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_busy <= w_busy_nxt;
      if (w_alu_win || w_pop) begin
        r_wr_addr <= w_win_rd;
        r_wr_val  <= w_win_data;
        r_wr_en   <= (w_win_rd != 5'd0);
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scenarios for writeback_arbiter; every enabled register-file write is matched
// in order against a queue of expected {rd, data} pairs filled as stimulus is driven.
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;
  logic [36:0] exp_q[$];

  writeback_arbiter_if #(.CNT_W(3)) bus();

  writeback_arbiter #(.LSU_FIFO_DEPTH(4), .CNT_W(3)) dut (
    .SYS_clk  (clk),
    .SYS_reset(rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge, then match any enabled write against the expected queue.
  task automatic tick();
    logic [36:0] e;
    @(posedge clk); #1;
    checks++;
    if (bus.fifo_count > 3'd4) begin
      errs++; $display("FAIL fifo_bound count=%0d required<=4", bus.fifo_count);
    end
    if (bus.REG_write_enable === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL wr_unexpected got rd=%0d data=%h required no write",
                 bus.REG_write_address, bus.REG_write_value);
      end else begin
        e = exp_q.pop_front();
        if ({bus.REG_write_address, bus.REG_write_value} !== e) begin
          errs++;
          $display("FAIL wr_order got rd=%0d data=%h required rd=%0d data=%h",
                   bus.REG_write_address, bus.REG_write_value, e[36:32], e[31:0]);
        end
      end
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.issue_valid = 1'b0; bus.issue_long = 1'b0; bus.issue_rd = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (bus.REG_write_enable !== 1'b0) begin errs++; $display("FAIL rst_en got %b required 0", bus.REG_write_enable); end
    checks++; if (bus.busy_mask !== 32'h0) begin errs++; $display("FAIL rst_busy got %h required 0", bus.busy_mask); end
    checks++; if (bus.fifo_count !== 3'd0) begin errs++; $display("FAIL rst_count got %0d required 0", bus.fifo_count); end
    checks++; if (bus.lsu_ready !== 1'b1) begin errs++; $display("FAIL rst_lsu_ready got %b required 1", bus.lsu_ready); end
    checks++; if (bus.alu_ready !== 1'b1) begin errs++; $display("FAIL rst_alu_ready got %b required 1", bus.alu_ready); end
  endtask

  task automatic test_alu_latency();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.REG_write_enable !== 1'b1 || bus.REG_write_address !== 5'd5)
      begin errs++; $display("FAIL alu_lat en=%b rd=%0d required en=1 rd=5", bus.REG_write_enable, bus.REG_write_address); end
    tick();
    checks++; if (bus.REG_write_enable !== 1'b0) begin errs++; $display("FAIL alu_deassert got %b required 0", bus.REG_write_enable); end
    checks++; if (bus.REG_write_value !== 32'hDEADBEEF) begin errs++; $display("FAIL alu_hold got %h required deadbeef", bus.REG_write_value); end
  endtask

  task automatic test_x0_discard();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errs++; $display("FAIL x0_ready got %b required 1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.REG_write_enable !== 1'b0) begin errs++; $display("FAIL x0_en got %b required 0", bus.REG_write_enable); end
    checks++; if (bus.REG_write_address !== 5'd0 || bus.REG_write_value !== 32'h1234)
      begin errs++; $display("FAIL x0_update rd=%0d data=%h required rd=0 data=1234", bus.REG_write_address, bus.REG_write_value); end
    tick();
  endtask

  task automatic test_scoreboard();
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd0;
    tick();
    checks++; if (bus.busy_mask !== 32'h0) begin errs++; $display("FAIL sb_x0 got %h required 0", bus.busy_mask); end
    bus.issue_rd = 5'd7;
    tick();
    bus.issue_valid = 1'b0;
    checks++; if (bus.busy_mask !== 32'h80) begin errs++; $display("FAIL sb_set got %h required 80", bus.busy_mask); end
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h55;
    tick();
    bus.lsu_valid = 1'b0;
    checks++; if (bus.busy_mask !== 32'h80 || bus.fifo_count !== 3'd1)
      begin errs++; $display("FAIL sb_push busy=%h count=%0d required busy=80 count=1", bus.busy_mask, bus.fifo_count); end
    exp_q.push_back({5'd7, 32'h55});
    tick();
    checks++; if (bus.busy_mask !== 32'h0 || bus.fifo_count !== 3'd0)
      begin errs++; $display("FAIL sb_clear busy=%h count=%0d required busy=0 count=0", bus.busy_mask, bus.fifo_count); end
    checks++; if (bus.REG_write_enable !== 1'b1) begin errs++; $display("FAIL sb_write got en=%b required 1", bus.REG_write_enable); end
  endtask

  task automatic test_full_priority();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10;
    for (int i = 1; i <= 4; i++) begin
      bus.alu_data = 32'hA000_0000 + i;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(i); bus.lsu_data = 32'h1000_0000 + i;
      exp_q.push_back({5'd10, 32'hA000_0000 + i});
      tick();
    end
    bus.lsu_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd4) begin errs++; $display("FAIL full_count got %0d required 4", bus.fifo_count); end
    checks++; if (bus.lsu_ready !== 1'b0 || bus.alu_ready !== 1'b0)
      begin errs++; $display("FAIL full_ready lsu=%b alu=%b required 0 0", bus.lsu_ready, bus.alu_ready); end
    bus.alu_data = 32'hA000_0005;
    exp_q.push_back({5'd1, 32'h1000_0001});
    tick();
    checks++; if (bus.fifo_count !== 3'd3 || bus.alu_ready !== 1'b1)
      begin errs++; $display("FAIL unfull count=%0d alu_ready=%b required 3 1", bus.fifo_count, bus.alu_ready); end
    exp_q.push_back({5'd10, 32'hA000_0005});
    tick();
    bus.alu_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      exp_q.push_back({5'(i), 32'h1000_0000 + i});
      tick();
    end
    checks++; if (bus.fifo_count !== 3'd0) begin errs++; $display("FAIL drain_count got %0d required 0", bus.fifo_count); end
  endtask

  task automatic test_setclear_reset();
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
    tick();
    bus.lsu_valid = 1'b0;
    bus.issue_valid = 1'b1;
    exp_q.push_back({5'd9, 32'h99});
    tick();
    bus.issue_valid = 1'b0;
    checks++; if (bus.busy_mask[9] !== 1'b1 || bus.fifo_count !== 3'd0)
      begin errs++; $display("FAIL set_wins busy=%h count=%0d required bit9=1 count=0", bus.busy_mask, bus.fifo_count); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd11;
    for (int i = 12; i <= 13; i++) begin
      bus.alu_data = 32'hB000_0000 + i;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(i); bus.lsu_data = 32'hC000_0000 + i;
      exp_q.push_back({5'd11, 32'hB000_0000 + i});
      tick();
    end
    bus.lsu_valid = 1'b0; bus.alu_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd2) begin errs++; $display("FAIL pre_rst_count got %0d required 2", bus.fifo_count); end
    rst = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    tick();
    rst = 1'b0; bus.issue_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd0 || bus.busy_mask !== 32'h0 || bus.REG_write_enable !== 1'b0)
      begin errs++; $display("FAIL mid_rst count=%0d busy=%h en=%b required 0 0 0", bus.fifo_count, bus.busy_mask, bus.REG_write_enable); end
    checks++; if (bus.REG_write_address !== 5'd0 || bus.REG_write_value !== 32'h0)
      begin errs++; $display("FAIL mid_rst_regs rd=%0d data=%h required 0 0", bus.REG_write_address, bus.REG_write_value); end
    tick(); tick();
    checks++; if (bus.REG_write_enable !== 1'b0 || bus.fifo_count !== 3'd0)
      begin errs++; $display("FAIL post_rst en=%b count=%0d required 0 0", bus.REG_write_enable, bus.fifo_count); end
  endtask

  initial begin
    test_reset();
    test_alu_latency();
    test_x0_discard();
    test_scoreboard();
    test_full_priority();
    test_setclear_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errs++; $display("FAIL wr_missing got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Producer end of the register-file write port.
- Collects completed results from the single-cycle ALU path and the multi-cycle load/store path, and drives the single REG_write_address/REG_write_enable/REG_write_value port into the register file.
- Buffers long-latency results in a small FIFO.
- Maintains a pending-destination scoreboard so decode can stall on RAW hazards against outstanding loads.

Parameters:
- LSU_FIFO_DEPTH, 4, number of buffered LSU results (power of two, ≥2).
- CNT_W, 3, width of fifo_count (log2(LSU_FIFO_DEPTH)+1).

Ports:
- SYS_clk  input  1  system clock; all state updates on rising edge.
- SYS_reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result available this cycle.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- alu_ready  output  1  ALU result accepted this cycle (combinational).
- lsu_valid  input  1  LSU result available.
- lsu_rd  input  5  LSU destination register.
- lsu_data  input  32  LSU result.
- lsu_ready  output  1  LSU result accepted (combinational, = !fifo_full).
- issue_valid  input  1  instruction issued this cycle.
- issue_long  input  1  issued instruction completes via LSU.
- issue_rd  input  5  destination of the issued instruction.
- REG_write_address  output  5  register-file write address (registered).
- REG_write_enable  output  1  register-file write strobe (registered).
- REG_write_value  output  32  register-file write data (registered).
- busy_mask  output  32  bit i = 1 while an LSU result for xi is outstanding.
- fifo_count  output  CNT_W  LSU FIFO occupancy.

Behaviour:
- Reset (SYS_reset=1 at clock edge): FIFO emptied, fifo_count=0, busy_mask=0, REG_write_enable=0, REG_write_address=0, REG_write_value=0. Reset overrides all inputs in the same cycle, including a mid-flight FIFO drain; buffered entries are discarded.
- LSU push: lsu_valid && lsu_ready writes {lsu_rd, lsu_data} at the tail. lsu_ready=0 when full; there is no push-on-pop when full.
- Write-slot arbitration (one write per cycle). The winner is decided combinationally from current state:
  1. If the FIFO is full and non-empty, the FIFO head wins and alu_ready=0.
  2. Else if alu_valid, the ALU wins and alu_ready=1.
  3. Else if the FIFO is non-empty, the FIFO head wins (pop).
  4. Else no write.
- alu_ready=1 whenever the FIFO is not full, even with alu_valid=0.
- The ALU does not stall except during the full case; the starvation bound for FIFO entries is the number of consecutive ALU results.
- Latency: the selected result appears on REG_write_* exactly one cycle after acceptance/pop. REG_write_enable=1 only if the winner's rd != 0. Otherwise enable=0, but the entry is still consumed and the address/value outputs still update.
- REG_write_enable deasserts the cycle after no winner is selected. Address and value hold their last values.
- FIFO: circular buffer with head and tail pointers that wrap modulo LSU_FIFO_DEPTH. A push and a pop in the same cycle leave fifo_count unchanged. Data ordering is strict FIFO.
- Scoreboard:
  - issue_valid && issue_long && issue_rd != 0 sets busy_mask[issue_rd] at the clock edge.
  - A FIFO pop clears busy_mask[head_rd] at the clock edge, not on push.
  - If a set and a clear target the same register in the same cycle, set wins.
  - busy_mask[0] is always 0.
  - ALU writes never modify busy_mask.
- No combinational path from any input to REG_write_*. The only combinational input-to-output paths are to alu_ready and lsu_ready.

Test Plan:
- Reset then idle: assert SYS_reset for 2 cycles → REG_write_enable=0, busy_mask=0, fifo_count=0, lsu_ready=1, alu_ready=1.
- ALU write latency: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle → next cycle REG_write_enable=1, address=5, value=0xDEADBEEF; the following cycle enable=0.
- x0 discard: alu_rd=0, alu_data=0x1234 → enable stays 0; the accept still happens (alu_ready=1).
- Scoreboard round-trip: issue x7 long → busy_mask=0x80. LSU returns rd=7, data=0x55 while the ALU is idle → write x7=0x55 one cycle after the pop, and busy_mask=0 on the pop edge.
- Full-FIFO priority:
  - Push 4 LSU results (rd 1..4) while alu_valid is held at 1 → lsu_ready=0, then alu_ready=0 when fifo_count=4.
  - The head (rd 1) is written next.
  - alu_ready returns to 1 when fifo_count=3.
  - Order on the write port: 1, ALU, 2, 3, 4 as arbitration dictates, and fifo_count never exceeds 4.
- Simultaneous set/clear plus reset mid-drain:
  - Pop rd=9 in the same cycle that issue_long sets rd=9 → busy_mask[9] stays 1.
  - Then assert SYS_reset with fifo_count=2 → next cycle fifo_count=0, busy_mask=0, REG_write_enable=0.
